// File: rtl/ysyx_040729_pkg.sv
// Shared types for the cache/AXI-bridge memory arbiter: FSM state encoding,
// grant encoding, default parameter values and the priority-pick helper.
package ysyx_040729_pkg;

    localparam int RW_DATA_WIDTH_DEF  = 256;
    localparam int AXI_ADDR_WIDTH_DEF = 32;
    localparam int STALL_LIMIT_DEF    = 1023;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2,
        WR   = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2,
        GNT_W    = 2'd3
    } grant_e;

    // Writeback always wins so a dirty line leaves before any later refill.
    // prefer_i only breaks a tie between the two refill reads.
    function automatic grant_e arb_pick(input logic w_req, input logic d_req,
                                        input logic i_req, input logic prefer_i);
        if (w_req)               return GNT_W;
        if (d_req && i_req)      return prefer_i ? GNT_I : GNT_D;
        if (d_req)               return GNT_D;
        if (i_req)               return GNT_I;
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/ysyx_040729_arb_watchdog.sv
// Stall watchdog for the memory arbiter: a saturating cycle counter cleared on
// every grant and advanced while a transaction is outstanding; the error flag
// sets when the counter reaches STALL_LIMIT and holds until reset.
module ysyx_040729_arb_watchdog
    import ysyx_040729_pkg::*;
#(
    parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic busy_i,
    output logic err_o
);

    localparam int CW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STALL_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Next count and sticky flag; the flag rises on the same edge the count reaches the limit.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (busy_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (busy_i && !clear_i && (cnt_d == LIMIT_C)) begin
            err_d = 1'b1;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/ysyx_040729_mem_arbiter.sv
// Memory arbiter between I-cache refill, D-cache refill and D-cache writeback
// and the single read/write port pair of the AXI bridge. One transaction is
// outstanding at a time; bridge-side request fields are registered.
// Optional feature macro: ARB_ROUND_ROBIN_EN -- when defined, the D/I refill
// tie is broken by a one-bit last-grant pointer instead of fixed D-first.
module ysyx_040729_mem_arbiter
    import ysyx_040729_pkg::*;
#(
    parameter int RW_DATA_WIDTH  = RW_DATA_WIDTH_DEF,
    parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
    parameter int STALL_LIMIT    = STALL_LIMIT_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [AXI_ADDR_WIDTH-1:0] i_r_addr,
    input  logic [2:0]                i_r_size,
    input  logic                      i_r_valid,
    output logic                      i_r_ready,
    output logic [RW_DATA_WIDTH-1:0]  i_r_data,
    input  logic [AXI_ADDR_WIDTH-1:0] d_r_addr,
    input  logic [2:0]                d_r_size,
    input  logic                      d_r_valid,
    output logic                      d_r_ready,
    output logic [RW_DATA_WIDTH-1:0]  d_r_data,
    input  logic [AXI_ADDR_WIDTH-1:0] d_w_addr,
    input  logic [2:0]                d_w_size,
    input  logic                      d_w_valid,
    input  logic [RW_DATA_WIDTH-1:0]  d_w_data,
    output logic                      d_w_ready,
    output logic [AXI_ADDR_WIDTH-1:0] r_addr_o,
    output logic [2:0]                r_size_o,
    output logic                      r_valid_o,
    input  logic                      r_ready_i,
    input  logic [RW_DATA_WIDTH-1:0]  r_data_i,
    output logic [AXI_ADDR_WIDTH-1:0] w_addr_o,
    output logic [2:0]                w_size_o,
    output logic [RW_DATA_WIDTH-1:0]  w_data_o,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    output logic                      err_timeout
);

    arb_state_e                state_q, state_d;
    grant_e                    grant;
    logic                      prefer_i;
    logic [AXI_ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [2:0]                r_size_q, r_size_d;
    logic                      r_valid_q, r_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [2:0]                w_size_q, w_size_d;
    logic [RW_DATA_WIDTH-1:0]  w_data_q, w_data_d;
    logic                      w_valid_q, w_valid_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = the D-cache refill won the most recent read grant (reset: I-cache).
    logic last_d_q, last_d_d;

    assign prefer_i = last_d_q;

    // Pointer moves only on a read grant; writebacks leave it alone.
    always_comb begin
        last_d_d = last_d_q;
        if (grant == GNT_D) last_d_d = 1'b1;
        if (grant == GNT_I) last_d_d = 1'b0;
    end

    // Last-grant pointer register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_d_q <= 1'b0;
        else       last_d_q <= last_d_d;
    end
`else
    assign prefer_i = 1'b0;
`endif

    // Arbitration in IDLE, then wait in the busy state for the bridge to finish.
    always_comb begin
        state_d   = state_q;
        grant     = GNT_NONE;
        r_addr_d  = r_addr_q;
        r_size_d  = r_size_q;
        r_valid_d = r_valid_q;
        w_addr_d  = w_addr_q;
        w_size_d  = w_size_q;
        w_data_d  = w_data_q;
        w_valid_d = w_valid_q;
        case (state_q)
            IDLE: begin
                grant = arb_pick(d_w_valid, d_r_valid, i_r_valid, prefer_i);
                case (grant)
                    GNT_W: begin
                        state_d   = WR;
                        w_addr_d  = d_w_addr;
                        w_size_d  = d_w_size;
                        w_data_d  = d_w_data;
                        w_valid_d = 1'b1;
                    end
                    GNT_D: begin
                        state_d   = RD_D;
                        r_addr_d  = d_r_addr;
                        r_size_d  = d_r_size;
                        r_valid_d = 1'b1;
                    end
                    GNT_I: begin
                        state_d   = RD_I;
                        r_addr_d  = i_r_addr;
                        r_size_d  = i_r_size;
                        r_valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            RD_I, RD_D: begin
                if (r_ready_i) begin
                    state_d   = IDLE;
                    r_valid_d = 1'b0;
                end
            end
            WR: begin
                if (w_ready_i) begin
                    state_d   = IDLE;
                    w_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered bridge-side request fields.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            r_addr_q  <= '0;
            r_size_q  <= '0;
            r_valid_q <= 1'b0;
            w_addr_q  <= '0;
            w_size_q  <= '0;
            w_data_q  <= '0;
            w_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_addr_q  <= r_addr_d;
            r_size_q  <= r_size_d;
            r_valid_q <= r_valid_d;
            w_addr_q  <= w_addr_d;
            w_size_q  <= w_size_d;
            w_data_q  <= w_data_d;
            w_valid_q <= w_valid_d;
        end
    end

    // Completion pulses follow the bridge ready in the same cycle, gated by state
    // so a stray ready in IDLE or on the other port is ignored.
    assign i_r_ready = (state_q == RD_I) & r_ready_i;
    assign d_r_ready = (state_q == RD_D) & r_ready_i;
    assign d_w_ready = (state_q == WR)   & w_ready_i;
    assign i_r_data  = r_data_i;
    assign d_r_data  = r_data_i;

    assign r_addr_o  = r_addr_q;
    assign r_size_o  = r_size_q;
    assign r_valid_o = r_valid_q;
    assign w_addr_o  = w_addr_q;
    assign w_size_o  = w_size_q;
    assign w_data_o  = w_data_q;
    assign w_valid_o = w_valid_q;

    ysyx_040729_arb_watchdog #(
        .STALL_LIMIT(STALL_LIMIT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear_i(grant != GNT_NONE),
        .busy_i (state_q != IDLE),
        .err_o  (err_timeout)
    );

endmodule

// File: tb/tb_ysyx_040729_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: requests are queued per requester,
// a reference model derives the service order, a bridge model answers with
// random latency, and a negedge monitor checks every completion.
module tb_ysyx_040729_mem_arbiter;

    localparam int RW = 256;
    localparam int AW = 32;
    localparam int SL = 16;

    typedef struct {
        int           kind;   // 0 = I refill, 1 = D refill, 2 = D writeback
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [RW-1:0] data;
    } req_t;

    logic          clock, reset;
    logic [AW-1:0] i_r_addr, d_r_addr, d_w_addr, r_addr_o, w_addr_o;
    logic [2:0]    i_r_size, d_r_size, d_w_size, r_size_o, w_size_o;
    logic          i_r_valid, d_r_valid, d_w_valid;
    logic          i_r_ready, d_r_ready, d_w_ready;
    logic [RW-1:0] i_r_data, d_r_data, d_w_data, r_data_i, w_data_o;
    logic          r_valid_o, r_ready_i, w_valid_o, w_ready_i, err_timeout;

    ysyx_040729_mem_arbiter #(
        .RW_DATA_WIDTH(RW), .AXI_ADDR_WIDTH(AW), .STALL_LIMIT(SL)
    ) dut (
        .clock(clock), .reset(reset),
        .i_r_addr(i_r_addr), .i_r_size(i_r_size), .i_r_valid(i_r_valid),
        .i_r_ready(i_r_ready), .i_r_data(i_r_data),
        .d_r_addr(d_r_addr), .d_r_size(d_r_size), .d_r_valid(d_r_valid),
        .d_r_ready(d_r_ready), .d_r_data(d_r_data),
        .d_w_addr(d_w_addr), .d_w_size(d_w_size), .d_w_valid(d_w_valid),
        .d_w_data(d_w_data), .d_w_ready(d_w_ready),
        .r_addr_o(r_addr_o), .r_size_o(r_size_o), .r_valid_o(r_valid_o),
        .r_ready_i(r_ready_i), .r_data_i(r_data_i),
        .w_addr_o(w_addr_o), .w_size_o(w_size_o), .w_data_o(w_data_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .err_timeout(err_timeout)
    );

    int vectors = 0;
    int miscompares = 0;

    req_t pend_i[$];
    req_t pend_d[$];
    req_t pend_w[$];
    req_t expq[$];

    bit            last_was_d = 0;
    bit            r_act = 0, w_act = 0, hang = 0, stray_en = 0, rdata_fix_en = 0;
    int            r_cnt = 0, w_cnt = 0, fixed_delay = -1;
    logic [RW-1:0] rdata_fix, br_rdata;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rand_line();
        logic [RW-1:0] v;
        for (int k = 0; k < RW / 32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic add_req(input int kind, input logic [AW-1:0] addr,
                           input logic [2:0] size, input logic [RW-1:0] data);
        req_t e;
        e.kind = kind; e.addr = addr; e.size = size; e.data = data;
        if (kind == 0) pend_i.push_back(e);
        else if (kind == 1) pend_d.push_back(e);
        else pend_w.push_back(e);
    endtask

    // Reference order: every queued request stays pending until served, so
    // writebacks drain first, then reads by fixed D-first or alternating tie.
    task automatic model_push();
        int ci, cd, cw;
        bit take_d;
        ci = 0; cd = 0; cw = 0;
        while (ci < pend_i.size() || cd < pend_d.size() || cw < pend_w.size()) begin
            if (cw < pend_w.size()) begin
                expq.push_back(pend_w[cw]);
                cw++;
            end else begin
                if (cd < pend_d.size() && ci < pend_i.size()) begin
`ifdef ARB_ROUND_ROBIN_EN
                    take_d = !last_was_d;
`else
                    take_d = 1'b1;
`endif
                end else begin
                    take_d = (cd < pend_d.size());
                end
                if (take_d) begin
                    expq.push_back(pend_d[cd]); cd++; last_was_d = 1'b1;
                end else begin
                    expq.push_back(pend_i[ci]); ci++; last_was_d = 1'b0;
                end
            end
        end
    endtask

    task automatic present();
        i_r_valid = (pend_i.size() != 0);
        d_r_valid = (pend_d.size() != 0);
        d_w_valid = (pend_w.size() != 0);
        if (i_r_valid) begin i_r_addr = pend_i[0].addr; i_r_size = pend_i[0].size; end
        if (d_r_valid) begin d_r_addr = pend_d[0].addr; d_r_size = pend_d[0].size; end
        if (d_w_valid) begin
            d_w_addr = pend_w[0].addr; d_w_size = pend_w[0].size; d_w_data = pend_w[0].data;
        end
    endtask

    // One clock: bridge model reacts after the edge, then requesters retire on ready.
    task automatic step();
        @(posedge clock);
        #1;
        if (r_ready_i) begin
            r_ready_i = 1'b0;
        end else if (r_valid_o) begin
            if (!r_act) begin
                r_act = 1'b1;
                r_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 6));
            end
            if (!hang) begin
                if (r_cnt == 0) begin
                    r_data_i  = rdata_fix_en ? rdata_fix : rand_line();
                    br_rdata  = r_data_i;
                    r_ready_i = 1'b1;
                    r_act     = 1'b0;
                end else begin
                    r_cnt--;
                end
            end
        end else if (stray_en && $urandom_range(0, 9) == 0) begin
            r_data_i  = rand_line();
            r_ready_i = 1'b1;
        end
        if (w_ready_i) begin
            w_ready_i = 1'b0;
        end else if (w_valid_o) begin
            if (!w_act) begin
                w_act = 1'b1;
                w_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 6));
            end
            if (!hang) begin
                if (w_cnt == 0) begin
                    w_ready_i = 1'b1;
                    w_act     = 1'b0;
                end else begin
                    w_cnt--;
                end
            end
        end else if (stray_en && $urandom_range(0, 9) == 0) begin
            w_ready_i = 1'b1;
        end
        #1;
        if (i_r_ready && pend_i.size() != 0) void'(pend_i.pop_front());
        if (d_r_ready && pend_d.size() != 0) void'(pend_d.pop_front());
        if (d_w_ready && pend_w.size() != 0) void'(pend_w.pop_front());
        present();
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((pend_i.size() != 0 || pend_d.size() != 0 || pend_w.size() != 0 ||
                expq.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: %0d requests left, required 0",
                     nm, pend_i.size() + pend_d.size() + pend_w.size() + expq.size());
        end
        step();
        step();
    endtask

    // Scoreboard monitor.
    int   mon_nrdy, mon_got;
    req_t mon_e;
    always @(negedge clock) begin
        if (!reset) begin
            mon_nrdy = int'(i_r_ready) + int'(d_r_ready) + int'(d_w_ready);
            if ((r_ready_i && r_valid_o) || (w_ready_i && w_valid_o)) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_completion: got completion, required none");
                end else begin
                    mon_e = expq.pop_front();
                    mon_got = d_w_ready ? 2 : (d_r_ready ? 1 : (i_r_ready ? 0 : 3));
                    chk("ready_count", mon_nrdy, 1);
                    chk("grant_kind", mon_got, mon_e.kind);
                    if (mon_e.kind == 2) begin
                        chk("w_addr", w_addr_o, mon_e.addr);
                        chk("w_size", w_size_o, mon_e.size);
                        chk("w_data", w_data_o, mon_e.data);
                    end else begin
                        chk("r_addr", r_addr_o, mon_e.addr);
                        chk("r_size", r_size_o, mon_e.size);
                        chk("r_data", (mon_e.kind == 1) ? d_r_data : i_r_data, br_rdata);
                    end
                end
            end else begin
                chk("no_spurious_ready", mon_nrdy, 0);
            end
        end
    end

    initial begin
        int k;
        int ni, nd, nw;
        reset = 1'b1;
        i_r_addr = '0; i_r_size = '0; i_r_valid = 1'b0;
        d_r_addr = '0; d_r_size = '0; d_r_valid = 1'b0;
        d_w_addr = '0; d_w_size = '0; d_w_valid = 1'b0; d_w_data = '0;
        r_ready_i = 1'b0; r_data_i = '0; w_ready_i = 1'b0;
        br_rdata = '0;
        rdata_fix = '0;
        for (int j = 0; j < RW / 32; j++) rdata_fix[32*j +: 32] = 32'hDEADBEEF;
        repeat (3) @(posedge clock);
        #3 reset = 1'b0;

        // Reset state.
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_w_valid", w_valid_o, 0);
        chk("rst_readies", {i_r_ready, d_r_ready, d_w_ready}, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_r_addr", r_addr_o, 0);
        chk("rst_w_data", w_data_o, 0);

        // I-only refill, bridge ready after 5 cycles, fixed data pattern.
        step();
        fixed_delay = 5;
        rdata_fix_en = 1'b1;
        add_req(0, 32'h8000_0000, 3'd5, '0);
        model_push();
        present();
        #1 chk("t1_valid_before_grant", r_valid_o, 0);
        step();
        chk("t1_valid_after_grant", r_valid_o, 1);
        chk("t1_addr_out", r_addr_o, 32'h8000_0000);
        wait_done("t1");
        chk("t1_back_idle", r_valid_o, 0);
        rdata_fix_en = 1'b0;
        fixed_delay = -1;

        // Simultaneous writeback, D refill of the same line, and I refill.
        add_req(2, 32'h8000_1000, 3'd5, rand_line());
        add_req(1, 32'h8000_1000, 3'd5, '0);
        add_req(0, 32'h8000_2000, 3'd5, '0);
        model_push();
        present();
        wait_done("t2");

        // Both refills held continuously for several requests each.
        for (int j = 0; j < 4; j++) begin
            add_req(1, 32'h8001_0000 + 32'(j * 32), 3'd5, '0);
            add_req(0, 32'h8002_0000 + 32'(j * 32), 3'd5, '0);
        end
        model_push();
        present();
        wait_done("t3");

        // Random batches with stray bridge readies.
        stray_en = 1'b1;
        for (int b = 0; b < 30; b++) begin
            ni = $urandom_range(0, 3);
            nd = $urandom_range(0, 3);
            nw = $urandom_range(0, 3);
            if (ni + nd + nw == 0) ni = 1;
            for (int j = 0; j < nw; j++) add_req(2, $urandom & ~32'h1f, 3'($urandom_range(0, 7)), rand_line());
            for (int j = 0; j < nd; j++) add_req(1, $urandom & ~32'h1f, 3'($urandom_range(0, 7)), '0);
            for (int j = 0; j < ni; j++) add_req(0, $urandom & ~32'h1f, 3'($urandom_range(0, 7)), '0);
            model_push();
            present();
            wait_done("rand");
        end
        stray_en = 1'b0;
        chk("no_timeout_in_normal_traffic", err_timeout, 0);

        // Bridge never readies: watchdog fires exactly STALL_LIMIT cycles after valid.
        hang = 1'b1;
        add_req(0, 32'h8000_3000, 3'd5, '0);
        model_push();
        present();
        k = 0;
        while (!r_valid_o && k < 10) begin step(); k++; end
        chk("t4_valid_seen", r_valid_o, 1);
        k = 0;
        while (!err_timeout && k < 40) begin step(); k++; end
        chk("t4_timeout_cycles", k, SL);
        hang = 1'b0;
        wait_done("t4");
        chk("t4_err_sticky", err_timeout, 1);

        // Reset in the middle of a D refill.
        hang = 1'b1;
        add_req(1, 32'h8000_4000, 3'd5, '0);
        model_push();
        present();
        k = 0;
        while (!r_valid_o && k < 10) begin step(); k++; end
        step();
        #2 reset = 1'b1;
        #1;
        chk("t5_r_valid_async", r_valid_o, 0);
        chk("t5_d_r_ready_async", d_r_ready, 0);
        chk("t5_err_async", err_timeout, 0);
        pend_d.delete();
        expq.delete();
        last_was_d = 1'b0;
        r_act = 1'b0;
        hang = 1'b0;
        present();
        step();
        #1 reset = 1'b0;
        @(posedge clock);
        #1 r_ready_i = 1'b1;
        #1;
        chk("t5_stray_i_ready", i_r_ready, 0);
        chk("t5_stray_d_ready", d_r_ready, 0);
        step();
        step();
        chk("t5_idle_after_stray", r_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
